// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte intake, circular FIFO, serial engine.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7 (8E1 frames).
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                         iCE_CLK,
  input  logic                         RST,
  input  logic [7:0]                   tx_byte,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         TX,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state;
  state_t          state_next;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            tx_next;

  logic            push;
  logic            pop;
  logic            bit_end;
  logic            queue_nonempty;

`ifdef UART_TX_PARITY_EN
  logic            parity_bit;
`endif

  // Handshake status comes only from registered count, never from tx_valid.
  assign tx_ready       = (count < DEPTH_C);
  assign push           = tx_valid && tx_ready;
  assign queue_nonempty = (count != '0);
  assign bit_end        = (state != IDLE) && (baud_cnt == BAUD_LAST);
  assign busy           = (state != IDLE) || queue_nonempty;
  assign fifo_count     = count;

  always_ff @(posedge iCE_CLK) begin
    if (push) begin
      mem[wr_ptr] <= tx_byte;
    end
  end

  always_ff @(posedge iCE_CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge iCE_CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (queue_nonempty) state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA: begin
        if (bit_end && (bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_next = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          state_next = queue_nonempty ? START : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A pop loads the next byte and drives the start bit on the same edge, so
  // back-to-back frames leave no idle gap after the stop bit.
  always_comb begin
    pop     = 1'b0;
    tx_next = TX;
    case (state)
      IDLE: begin
        pop     = queue_nonempty;
        tx_next = !queue_nonempty;
      end
      START: if (bit_end) tx_next = shift[0];
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_next = parity_bit;
`else
            tx_next = 1'b1;
`endif
          end else begin
            tx_next = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) tx_next = 1'b1;
`endif
      STOP: begin
        if (bit_end) begin
          pop     = queue_nonempty;
          tx_next = !queue_nonempty;
        end
      end
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge iCE_CLK or posedge RST) begin
    if (RST) begin
      TX       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      TX <= tx_next;
      if ((state == IDLE) || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_cnt <= '0;
      end else if ((state == DATA) && bit_end) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge iCE_CLK or posedge RST) begin
    if (RST) begin
      parity_bit <= 1'b0;
    end else if (pop) begin
      parity_bit <= ^mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: randomized producer traffic against a
// frame-position reference model, plus directed single/burst/reset/baud-scaling cases.
module tb_uart_tx_buffered;

  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int SLOW_CPB = 104;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_LEN  = FRAME_BITS * CPB;
  localparam int SLOW_FRAME = FRAME_BITS * SLOW_CPB;

  logic       iCE_CLK = 1'b0;
  logic       RST;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       TX;
  logic       busy;
  logic [2:0] fifo_count;

  logic [7:0] slow_byte;
  logic       slow_valid;
  logic       slow_ready;
  logic       slow_tx;
  logic       slow_busy;
  logic [2:0] slow_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending bytes, plus position (in cycles) inside the frame on the line.
  logic [7:0] model_q[$];
  int         frame_pos = -1;
  logic [7:0] cur = 8'h00;
  bit         last_accepted = 1'b0;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
    .iCE_CLK(iCE_CLK), .RST(RST), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .TX(TX), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(SLOW_CPB), .FIFO_DEPTH(DEPTH)) u_dut_slow (
    .iCE_CLK(iCE_CLK), .RST(RST), .tx_byte(slow_byte), .tx_valid(slow_valid),
    .tx_ready(slow_ready), .TX(slow_tx), .busy(slow_busy), .fifo_count(slow_count)
  );

  always #5 iCE_CLK = ~iCE_CLK;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Line level of frame bit idx: 0 start, 1..8 data LSB first, then parity (if built) and stop.
  function automatic logic frameBit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic expTx();
    if (frame_pos < 0) return 1'b1;
    return frameBit(cur, frame_pos / CPB);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] b);
    tx_valid = valid;
    tx_byte  = b;
  endtask

  // One clock: advance the model on the edge, then compare every output 1 ns later.
  task automatic stepCycle();
    bit ready_pre;
    @(posedge iCE_CLK);
    if (RST) begin
      model_q.delete();
      frame_pos     = -1;
      last_accepted = 1'b0;
    end else begin
      ready_pre = (model_q.size() < DEPTH);
      if (frame_pos < 0) begin
        if (model_q.size() > 0) begin
          cur       = model_q.pop_front();
          frame_pos = 0;
        end
      end else begin
        frame_pos++;
        if (frame_pos == FRAME_LEN) begin
          if (model_q.size() > 0) begin
            cur       = model_q.pop_front();
            frame_pos = 0;
          end else begin
            frame_pos = -1;
          end
        end
      end
      last_accepted = tx_valid && ready_pre;
      if (last_accepted) model_q.push_back(tx_byte);
    end
    #1;
    checkOutput("tx", 32'(TX), 32'(expTx()));
    checkOutput("fifo_count", 32'(fifo_count), 32'(model_q.size()));
    checkOutput("tx_ready", 32'(tx_ready), 32'(model_q.size() < DEPTH));
    checkOutput("busy", 32'(busy), 32'((frame_pos >= 0) || (model_q.size() != 0)));
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (((frame_pos >= 0) || (model_q.size() != 0)) && (n < budget)) begin
      stepCycle();
      n++;
    end
    if ((frame_pos >= 0) || (model_q.size() != 0)) checkOutput("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic sendSingle(input logic [7:0] b, input logic [10:0] exp_bits);
    waitIdle(2000);
    applyStimulus(1'b1, b);
    stepCycle();
    applyStimulus(1'b0, 8'h00);
    checkOutput("single_accept", 32'(last_accepted), 32'd1);
    checkOutput("single_tx_before_start", 32'(TX), 32'd1);
    for (int o = 0; o <= FRAME_LEN; o++) begin
      stepCycle();
      if ((o < FRAME_LEN) && ((o % CPB) == CPB / 2))
        checkOutput("frame_bit", 32'(TX), 32'(exp_bits[o / CPB]));
      if (o == FRAME_LEN - 1) checkOutput("busy_last_cycle", 32'(busy), 32'd1);
      if (o == FRAME_LEN) checkOutput("busy_end", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int n;
    RST        = 1'b1;
    tx_valid   = 1'b0;
    tx_byte    = 8'h00;
    slow_valid = 1'b0;
    slow_byte  = 8'h00;

    stepCycle();
    stepCycle();
    checkOutput("rst_tx", 32'(TX), 32'd1);
    checkOutput("rst_ready", 32'(tx_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    RST = 1'b0;
    stepCycle();

    // Single frames; expected line bits written out by hand, index 0 = start bit.
`ifdef UART_TX_PARITY_EN
    sendSingle(8'hA5, 11'h54A);
    sendSingle(8'h07, 11'h60E);
    sendSingle(8'h03, 11'h406);
`else
    sendSingle(8'hA5, 11'h34A);
    sendSingle(8'h07, 11'h20E);
    sendSingle(8'h03, 11'h206);
`endif

    // Burst until full, then hold 0x66 across the pop edge.
    waitIdle(2000);
    for (int b = 1; b <= 5; b++) begin
      applyStimulus(1'b1, 8'(b));
      stepCycle();
    end
    checkOutput("burst_count", 32'(fifo_count), 32'd4);
    checkOutput("burst_ready", 32'(tx_ready), 32'd0);
    applyStimulus(1'b1, 8'h66);
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (!last_accepted && (n < 200));
    applyStimulus(1'b0, 8'h00);
    checkOutput("hold_cycles", 32'(n), 32'(FRAME_LEN - 2));
    checkOutput("refill_count", 32'(fifo_count), 32'd4);
    waitIdle(2000);

    // Reset during data bit 3 of 0xC3 with two bytes queued.
    applyStimulus(1'b1, 8'hC3); stepCycle();
    applyStimulus(1'b1, 8'h11); stepCycle();
    applyStimulus(1'b1, 8'h22); stepCycle();
    applyStimulus(1'b0, 8'h00);
    n = 0;
    while ((frame_pos != 4 * CPB + 1) && (n < 100)) begin
      stepCycle();
      n++;
    end
    checkOutput("pre_rst_pos", 32'(frame_pos), 32'(4 * CPB + 1));
    checkOutput("pre_rst_tx", 32'(TX), 32'd0);
    checkOutput("pre_rst_count", 32'(fifo_count), 32'd2);
    RST = 1'b1;
    #1;
    checkOutput("async_rst_tx", 32'(TX), 32'd1);
    checkOutput("async_rst_count", 32'(fifo_count), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_ready", 32'(tx_ready), 32'd1);
    stepCycle();
    stepCycle();
    RST = 1'b0;
    for (int i = 0; i < 3 * FRAME_LEN; i++) stepCycle();

    // Randomized producer: holds each offered byte until accepted, rate varies by phase.
    for (int phase = 0; phase < 5; phase++) begin
      int rate = $urandom_range(1, 4);
      for (int i = 0; i < 200; i++) begin
        if (!tx_valid || last_accepted)
          applyStimulus($urandom_range(0, 4) < rate, 8'($urandom));
        stepCycle();
      end
    end
    applyStimulus(1'b0, 8'h00);
    waitIdle(3000);

    // Baud scaling on the 104-clocks-per-bit instance: check first and last cycle of every bit.
    checkOutput("slow_ready", 32'(slow_ready), 32'd1);
    slow_valid = 1'b1;
    slow_byte  = 8'h55;
    @(posedge iCE_CLK);
    #1;
    slow_valid = 1'b0;
    checkOutput("slow_accept_count", 32'(slow_count), 32'd1);
    checkOutput("slow_tx_idle", 32'(slow_tx), 32'd1);
    for (int t = 1; t <= SLOW_FRAME + 1; t++) begin
      int o;
      @(posedge iCE_CLK);
      #1;
      o = t - 1;
      if ((o < SLOW_FRAME) && (((o % SLOW_CPB) == 0) || ((o % SLOW_CPB) == SLOW_CPB - 1)))
        checkOutput("slow_bit", 32'(slow_tx), 32'(frameBit(8'h55, o / SLOW_CPB)));
      if (o == SLOW_FRAME - 1) checkOutput("slow_busy_last", 32'(slow_busy), 32'd1);
      if (o == SLOW_FRAME) begin
        checkOutput("slow_busy_end", 32'(slow_busy), 32'd0);
        checkOutput("slow_tx_end", 32'(slow_tx), 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
